// File: rtl/actuador_puertas.sv
// Door actuator: reactive door model driving the open/close motor lines.
// Ports: clk, rst_n | salida_puertas[1:0] cmd, sensor obstruction,
//   limpiar_falla clear | puertas[1:0] status, motor_abrir, motor_cerrar,
//   timeout dwell pulse, falla fault flag, reintentos[1:0] reversal count.
module actuador_puertas #(
    parameter int T_RECORRIDO    = 4,
    parameter int T_ESPERA       = 8,
    parameter int MAX_REINTENTOS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] salida_puertas,
    input  logic       sensor,
    input  logic       limpiar_falla,
    output logic [1:0] puertas,
    output logic       motor_abrir,
    output logic       motor_cerrar,
    output logic       timeout,
    output logic       falla,
    output logic [1:0] reintentos
);

    localparam int T_MAX =
        (T_RECORRIDO > T_ESPERA) ? T_RECORRIDO : T_ESPERA;
    localparam int CNT_W = $clog2(T_MAX + 1);

    localparam logic [2:0] S_CERRADA  = 3'd0;
    localparam logic [2:0] S_ABRIENDO = 3'd1;
    localparam logic [2:0] S_ABIERTA  = 3'd2;
    localparam logic [2:0] S_CERRANDO = 3'd3;
    localparam logic [2:0] S_FALLA    = 3'd4;

    localparam logic [1:0] CMD_ABRIR  = 2'b01;
    localparam logic [1:0] CMD_CERRAR = 2'b10;

    localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(T_RECORRIDO - 1);
    localparam logic [CNT_W-1:0] ESP_LAST = CNT_W'(T_ESPERA - 1);
    localparam logic [CNT_W-1:0] ESP_SAT  = CNT_W'(T_ESPERA);
    localparam logic [31:0]      MAX_R    = 32'(MAX_REINTENTOS);

    logic [2:0]       estado_q, estado_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       reint_q, reint_d;
    logic [1:0]       reint_inc;
    logic             agota;

    // Saturating reversal count and the fault decision on the new value.
    assign reint_inc = (reint_q == 2'd3) ? 2'd3 : reint_q + 2'd1;
    assign agota     = ({30'd0, reint_inc} >= MAX_R);

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        reint_d  = reint_q;
        case (estado_q)
            S_CERRADA: begin
                if (salida_puertas == CMD_ABRIR) begin
                    estado_d = S_ABRIENDO;
                    cnt_d    = '0;
                end
            end
            S_ABRIENDO: begin
                if (cnt_q == REC_LAST) begin
                    estado_d = S_ABIERTA;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ABIERTA: begin
                if (salida_puertas == CMD_ABRIR) begin
                    cnt_d = '0;
                end else if (salida_puertas == CMD_CERRAR) begin
                    // A blocked close request only re-arms the dwell.
                    cnt_d = '0;
                    if (!sensor) begin
                        estado_d = S_CERRANDO;
                    end
                end else if (cnt_q != ESP_SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CERRANDO: begin
                // Obstruction wins over travel completion.
                if (sensor) begin
                    reint_d  = reint_inc;
                    cnt_d    = '0;
                    estado_d = agota ? S_FALLA : S_ABRIENDO;
                end else if (cnt_q == REC_LAST) begin
                    estado_d = S_CERRADA;
                    cnt_d    = '0;
                    reint_d  = 2'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FALLA: begin
                if (limpiar_falla) begin
                    estado_d = S_ABRIENDO;
                    cnt_d    = '0;
                end
            end
            default: begin
                estado_d = S_CERRADA;
                cnt_d    = '0;
            end
        endcase
        if (limpiar_falla) begin
            reint_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= S_CERRADA;
            cnt_q    <= '0;
            reint_q  <= 2'd0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            reint_q  <= reint_d;
        end
    end

    // Fault reports as open: the door is parked open with motors off.
    assign puertas      = (estado_q == S_FALLA) ? 2'b10 : estado_q[1:0];
    assign motor_abrir  = (estado_q == S_ABRIENDO);
    assign motor_cerrar = (estado_q == S_CERRANDO);
    assign timeout      = (estado_q == S_ABIERTA) && (cnt_q == ESP_LAST);
    assign falla        = (estado_q == S_FALLA);
    assign reintentos   = reint_q;

endmodule

// File: tb/tb_actuador_puertas.sv
// Directed bench for actuador_puertas (T_RECORRIDO=4, T_ESPERA=8, MAX=3).
// Inputs change 1 time unit after each rising edge; outputs sampled there.
module tb_actuador_puertas;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] salida_puertas = 2'b00;
    logic       sensor = 1'b0;
    logic       limpiar_falla = 1'b0;
    logic [1:0] puertas;
    logic       motor_abrir;
    logic       motor_cerrar;
    logic       timeout;
    logic       falla;
    logic [1:0] reintentos;

    int checks = 0;
    int errors = 0;

    actuador_puertas #(
        .T_RECORRIDO(4),
        .T_ESPERA(8),
        .MAX_REINTENTOS(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .salida_puertas(salida_puertas),
        .sensor(sensor),
        .limpiar_falla(limpiar_falla),
        .puertas(puertas),
        .motor_abrir(motor_abrir),
        .motor_cerrar(motor_cerrar),
        .timeout(timeout),
        .falla(falla),
        .reintentos(reintentos)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // CERRADA -> ABIERTA; returns in the first open cycle.
    task automatic open_door();
        salida_puertas = 2'b01;
        tick(1);
        salida_puertas = 2'b00;
        tick(4);
    endtask

    // From ABIERTA: start closing, obstruct on closing cycle 1.
    task automatic close_blocked();
        salida_puertas = 2'b10;
        tick(1);
        salida_puertas = 2'b00;
        sensor = 1'b1;
        tick(1);
        sensor = 1'b0;
    endtask

    task automatic test_reset();
        tick(2);
        checks++;
        if (puertas !== 2'b00) begin
            errors++;
            $display("FAIL reset_puertas got %b want 00", puertas);
        end
        checks++;
        if (motor_abrir !== 1'b0 || motor_cerrar !== 1'b0) begin
            errors++;
            $display("FAIL reset_motors got %b%b want 00",
                     motor_abrir, motor_cerrar);
        end
        checks++;
        if (timeout !== 1'b0 || falla !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got %b%b want 00", timeout, falla);
        end
        checks++;
        if (reintentos !== 2'd0) begin
            errors++;
            $display("FAIL reset_reint got %0d want 0", reintentos);
        end
        rst_n = 1'b1;
        tick(2);
        checks++;
        if (puertas !== 2'b00) begin
            errors++;
            $display("FAIL idle_puertas got %b want 00", puertas);
        end
    endtask

    task automatic test_open();
        salida_puertas = 2'b01;
        tick(1);
        salida_puertas = 2'b00;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (puertas !== 2'b01 || motor_abrir !== 1'b1) begin
                errors++;
                $display("FAIL opening_c%0d got %b/%b want 01/1",
                         i, puertas, motor_abrir);
            end
            tick(1);
        end
        checks++;
        if (puertas !== 2'b10 || motor_abrir !== 1'b0) begin
            errors++;
            $display("FAIL opened got %b/%b want 10/0",
                     puertas, motor_abrir);
        end
    endtask

    task automatic test_timeout();
        for (int j = 1; j <= 28; j++) begin
            checks++;
            if (timeout !== (j == 8)) begin
                errors++;
                $display("FAIL timeout_c%0d got %b want %b",
                         j, timeout, (j == 8));
            end
            tick(1);
        end
        checks++;
        if (puertas !== 2'b10) begin
            errors++;
            $display("FAIL still_open got %b want 10", puertas);
        end
    endtask

    task automatic test_close();
        salida_puertas = 2'b10;
        tick(1);
        salida_puertas = 2'b00;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (puertas !== 2'b11 || motor_cerrar !== 1'b1) begin
                errors++;
                $display("FAIL closing_c%0d got %b/%b want 11/1",
                         i, puertas, motor_cerrar);
            end
            tick(1);
        end
        checks++;
        if (puertas !== 2'b00 || reintentos !== 2'd0) begin
            errors++;
            $display("FAIL closed got %b/%0d want 00/0",
                     puertas, reintentos);
        end
        open_door();
        salida_puertas = 2'b10;
        tick(1);
        salida_puertas = 2'b00;
        tick(1);
        sensor = 1'b1;
        tick(1);
        sensor = 1'b0;
        checks++;
        if (puertas !== 2'b01 || reintentos !== 2'd1) begin
            errors++;
            $display("FAIL reversal got %b/%0d want 01/1",
                     puertas, reintentos);
        end
        tick(4);
        checks++;
        if (puertas !== 2'b10 || reintentos !== 2'd1) begin
            errors++;
            $display("FAIL reopened got %b/%0d want 10/1",
                     puertas, reintentos);
        end
        salida_puertas = 2'b10;
        tick(1);
        salida_puertas = 2'b00;
        tick(4);
        checks++;
        if (puertas !== 2'b00 || reintentos !== 2'd0) begin
            errors++;
            $display("FAIL clean_close got %b/%0d want 00/0",
                     puertas, reintentos);
        end
    endtask

    task automatic test_fault();
        open_door();
        close_blocked();
        tick(4);
        close_blocked();
        checks++;
        if (reintentos !== 2'd2 || falla !== 1'b0) begin
            errors++;
            $display("FAIL second_rev got %0d/%b want 2/0",
                     reintentos, falla);
        end
        tick(4);
        close_blocked();
        checks++;
        if (falla !== 1'b1 || puertas !== 2'b10) begin
            errors++;
            $display("FAIL fault got %b/%b want 1/10", falla, puertas);
        end
        checks++;
        if (motor_abrir !== 1'b0 || motor_cerrar !== 1'b0) begin
            errors++;
            $display("FAIL fault_motors got %b%b want 00",
                     motor_abrir, motor_cerrar);
        end
        checks++;
        if (reintentos !== 2'd3) begin
            errors++;
            $display("FAIL fault_reint got %0d want 3", reintentos);
        end
        salida_puertas = 2'b10;
        sensor = 1'b1;
        tick(3);
        salida_puertas = 2'b00;
        sensor = 1'b0;
        checks++;
        if (falla !== 1'b1 || puertas !== 2'b10 || motor_cerrar !== 1'b0) begin
            errors++;
            $display("FAIL fault_hold got %b/%b/%b want 1/10/0",
                     falla, puertas, motor_cerrar);
        end
        limpiar_falla = 1'b1;
        tick(1);
        limpiar_falla = 1'b0;
        checks++;
        if (puertas !== 2'b01 || falla !== 1'b0 || reintentos !== 2'd0) begin
            errors++;
            $display("FAIL clear got %b/%b/%0d want 01/0/0",
                     puertas, falla, reintentos);
        end
        tick(4);
    endtask

    task automatic test_rearm();
        checks++;
        if (puertas !== 2'b10) begin
            errors++;
            $display("FAIL rearm_start got %b want 10", puertas);
        end
        tick(5);
        salida_puertas = 2'b10;
        sensor = 1'b1;
        tick(1);
        salida_puertas = 2'b00;
        sensor = 1'b0;
        checks++;
        if (puertas !== 2'b10) begin
            errors++;
            $display("FAIL blocked_stay got %b want 10", puertas);
        end
        for (int j = 1; j <= 10; j++) begin
            checks++;
            if (timeout !== (j == 8)) begin
                errors++;
                $display("FAIL rearm_to_c%0d got %b want %b",
                         j, timeout, (j == 8));
            end
            tick(1);
        end
    endtask

    task automatic test_reset_mid();
        salida_puertas = 2'b10;
        tick(1);
        salida_puertas = 2'b00;
        tick(1);
        checks++;
        if (puertas !== 2'b11) begin
            errors++;
            $display("FAIL pre_reset got %b want 11", puertas);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (puertas !== 2'b00 || motor_cerrar !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got %b/%b want 00/0",
                     puertas, motor_cerrar);
        end
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checks++;
            if (puertas !== 2'b00 || motor_cerrar !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_c%0d got %b/%b want 00/0",
                         i, puertas, motor_cerrar);
            end
        end
    endtask

    initial begin
        test_reset();
        test_open();
        test_timeout();
        test_close();
        test_fault();
        test_rearm();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
